mem_port: RTL and testbench

MEM_PORT -- requirements
Module: mem_port

---
 rtl/mem_port_if.sv | 23 ++
 rtl/mem_port.sv | 118 +++++++++++
 tb/tb_mem_port.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_if.sv
// Core-side command/response bundle of a per-core memory port.
interface mem_port_if #(
    parameter int WIDTH = 32
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_wren;
    logic [WIDTH-1:0] cmd_address;
    logic [WIDTH-1:0] cmd_data;
    logic             rsp_valid;
    logic             rsp_err;
    logic [WIDTH-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_wren, cmd_address, cmd_data,
        input  cmd_ready, rsp_valid, rsp_err, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_wren, cmd_address, cmd_data,
        output cmd_ready, rsp_valid, rsp_err, rsp_data
    );
endinterface

// File: rtl/mem_port.sv
// Per-core memory port: 2-deep command queue feeding the arbiter
// request/response handshake, with a per-request timeout.
module mem_port #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    mem_port_if.slave        core,
    output logic             request,
    output logic             wren_core,
    output logic [WIDTH-1:0] address_out,
    output logic [WIDTH-1:0] data_out,
    input  logic [WIDTH-1:0] data_in,
    input  logic             response,
    output logic             busy
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef struct packed {
        logic             wren;
        logic [WIDTH-1:0] addr;
        logic [WIDTH-1:0] data;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

    state_t        state;
    cmd_t          q [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    count;
    logic [CW-1:0] wait_cnt;
    logic          rsp_valid;
    logic          rsp_err;
    logic [WIDTH-1:0] rsp_data;
    logic          push;
    logic          pop;
    cmd_t          head;

    assign core.cmd_ready = (count < 2'd2);
    assign core.rsp_valid = rsp_valid;
    assign core.rsp_err   = rsp_err;
    assign core.rsp_data  = rsp_data;

    assign push = core.cmd_valid && core.cmd_ready;
    // Head is only launched from IDLE or GAP; REQ holds the bus steady.
    assign pop  = (state != REQ) && (count != 2'd0);
    assign head = q[rd_ptr];
    assign busy = (state != IDLE) || (count != 2'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
            wait_cnt    <= '0;
            request     <= 1'b0;
            wren_core   <= 1'b0;
            address_out <= '0;
            data_out    <= '0;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_data    <= '0;
        end else begin
            rsp_valid <= 1'b0;
            if (push) begin
                q[wr_ptr] <= '{core.cmd_wren, core.cmd_address, core.cmd_data};
                wr_ptr    <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};

            unique case (state)
                IDLE, GAP: begin
                    if (pop) begin
                        address_out <= head.addr;
                        data_out    <= head.data;
                        wren_core   <= head.wren;
                        request     <= 1'b1;
                        wait_cnt    <= '0;
                        state       <= REQ;
                    end else begin
                        state <= IDLE;
                    end
                end
                REQ: begin
                    // A response on the timeout edge still counts as success.
                    if (response) begin
                        rsp_data  <= data_in;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        request   <= 1'b0;
                        wren_core <= 1'b0;
                        state     <= GAP;
                    end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        request   <= 1'b0;
                        wren_core <= 1'b0;
                        state     <= GAP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    request   <= 1'b0;
                    wren_core <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port.sv
// Scoreboard bench for mem_port: random traffic against a behavioural
// arbiter model, plus directed timeout, back-pressure and reset cases.
module tb_mem_port;
    localparam int W  = 32;
    localparam int TO = 8;

    typedef struct {
        logic         wren;
        logic [W-1:0] addr;
        logic [W-1:0] data;
    } cmd_s;

    typedef struct {
        logic         err;
        logic [W-1:0] data;
    } rsp_s;

    logic         clk = 1'b0;
    logic         reset;
    logic         request;
    logic         wren_core;
    logic [W-1:0] address_out;
    logic [W-1:0] data_out;
    logic [W-1:0] data_in;
    logic         response;
    logic         busy;

    mem_port_if #(.WIDTH(W)) cif ();

    mem_port #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .core        (cif),
        .request     (request),
        .wren_core   (wren_core),
        .address_out (address_out),
        .data_out    (data_out),
        .data_in     (data_in),
        .response    (response),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    cmd_s issue_q [$];
    rsp_s exp_q [$];
    int   gap_q [$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   done_cyc = -100;
    bit   arb_en = 1'b0;
    bit   stray_req = 1'b0;
    int   force_k = 0;
    logic [W-1:0] force_d = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endfunction

    // Monitor: every completion pulse consumes one expected response.
    initial begin : monitor
        rsp_s e;
        forever begin
            @(negedge clk);
            if (cif.rsp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_err", cif.rsp_err, e.err);
                    chk("rsp_data", cif.rsp_data, e.data);
                end
            end
        end
    end

    // Arbiter model: answers k cycles after request, or never if k > TO.
    initial begin : arbiter
        cmd_s         c;
        int           k;
        int           lim;
        logic [W-1:0] d;
        response = 1'b0;
        data_in  = '0;
        forever begin
            @(negedge clk);
            if (arb_en && request === 1'b1) begin
                gap_q.push_back(cyc - done_cyc);
                c = '{1'b0, '0, '0};
                if (issue_q.size() == 0) begin
                    chk("spurious_request", 1, 0);
                end else begin
                    c = issue_q.pop_front();
                    chk("wren_core", wren_core, c.wren);
                    chk("address_out", address_out, c.addr);
                    chk("data_out", data_out, c.data);
                end
                k = (force_k != 0) ? force_k : $urandom_range(1, TO + 2);
                d = (force_k != 0) ? force_d : $urandom;
                if (k <= TO) begin
                    exp_q.push_back('{1'b0, d});
                    lim = k;
                end else begin
                    exp_q.push_back('{1'b1, '0});
                    lim = TO;
                end
                for (int j = 1; j <= lim; j++) begin
                    if (j == k) begin
                        response = 1'b1;
                        data_in  = d;
                    end else begin
                        data_in = $urandom;
                    end
                    @(negedge clk);
                    response = 1'b0;
                    if (j < lim) begin
                        chk("req_held", request, 1);
                        chk("addr_stable", address_out, c.addr);
                        chk("data_stable", data_out, c.data);
                    end
                end
                chk("req_drop", request, 0);
                chk("wren_drop", wren_core, 0);
                done_cyc = cyc;
            end else if (stray_req && request === 1'b0) begin
                response  = 1'b1;
                data_in   = 32'hAAAA5555;
                stray_req = 1'b0;
                @(negedge clk);
                response = 1'b0;
            end
        end
    end

    task automatic send(input logic wr, input logic [W-1:0] a,
                        input logic [W-1:0] dd, output int waits);
        cif.cmd_valid   = 1'b1;
        cif.cmd_wren    = wr;
        cif.cmd_address = a;
        cif.cmd_data    = dd;
        waits = 0;
        while (cif.cmd_ready !== 1'b1 && waits < 200) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 200) chk("cmd_ready_timeout", 0, 1);
        else issue_q.push_back('{wr, a, dd});
        @(negedge clk);
        cif.cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (!(busy === 1'b0 && exp_q.size() == 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("drain_timeout", 0, 1);
        @(negedge clk);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        int w [4];
        int wt;
        reset           = 1'b1;
        cif.cmd_valid   = 1'b0;
        cif.cmd_wren    = 1'b0;
        cif.cmd_address = '0;
        cif.cmd_data    = '0;
        repeat (3) @(negedge clk);
        chk("rst_request", request, 0);
        chk("rst_wren", wren_core, 0);
        chk("rst_addr", address_out, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_rsp_valid", cif.rsp_valid, 0);
        chk("rst_rsp_err", cif.rsp_err, 0);
        chk("rst_rsp_data", cif.rsp_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", cif.cmd_ready, 1);
        reset  = 1'b0;
        arb_en = 1'b1;

        force_k = 3;
        force_d = 32'hDEADBEEF;
        send(1'b0, 32'h10, 32'h0, wt);
        drain();
        chk("load_hold", cif.rsp_data, 32'hDEADBEEF);

        force_d = 32'h00001234;
        send(1'b1, 32'h20, 32'h55, wt);
        drain();
        chk("store_rsp_hold", cif.rsp_data, 32'h00001234);

        stray_req = 1'b1;
        repeat (4) @(negedge clk);
        chk("stray_no_valid", cif.rsp_valid, 0);
        chk("stray_rsp_data", cif.rsp_data, 32'h00001234);
        chk("stray_busy", busy, 0);

        force_k = TO;
        gap_q.delete();
        send(1'b0, 32'h100, 32'h1, w[0]);
        send(1'b1, 32'h104, 32'h2, w[1]);
        send(1'b0, 32'h108, 32'h3, w[2]);
        send(1'b1, 32'h10C, 32'h4, w[3]);
        chk("burst_wait0", w[0], 0);
        chk("burst_wait1", w[1], 0);
        chk("burst_wait2", w[2], 0);
        chk("burst_full", (w[3] > 0), 1);
        drain();
        if (gap_q.size() < 4) begin
            chk("burst_gap_count", gap_q.size(), 4);
        end else begin
            for (int i = 1; i < 4; i++) chk("burst_gap", gap_q[i], 1);
        end

        force_k = TO + 1;
        send(1'b0, 32'h40, 32'h0, wt);
        send(1'b0, 32'h44, 32'h0, wt);
        drain();
        chk("timeout_err_hold", cif.rsp_err, 1);
        chk("timeout_data_hold", cif.rsp_data, 0);

        force_k = 0;
        for (int i = 0; i < 60; i++) begin
            send(1'($urandom_range(0, 1)), $urandom, $urandom, wt);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain();

        arb_en = 1'b0;
        send(1'b0, 32'h80, 32'h0, wt);
        send(1'b1, 32'h84, 32'h9, wt);
        @(negedge clk);
        chk("pre_rst_request", request, 1);
        reset           = 1'b1;
        cif.cmd_valid   = 1'b1;
        cif.cmd_address = 32'hBAD;
        @(negedge clk);
        reset         = 1'b0;
        cif.cmd_valid = 1'b0;
        chk("mid_rst_request", request, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", cif.cmd_ready, 1);
        chk("mid_rst_valid", cif.rsp_valid, 0);
        chk("mid_rst_wren", wren_core, 0);
        issue_q.delete();
        repeat (20) @(negedge clk);
        chk("post_rst_busy", busy, 0);

        arb_en  = 1'b1;
        force_k = 2;
        force_d = 32'hC0FFEE00;
        send(1'b0, 32'h90, 32'h0, wt);
        drain();
        chk("recover_data", cif.rsp_data, 32'hC0FFEE00);

        chk("exp_q_empty", exp_q.size(), 0);
        chk("issue_q_empty", issue_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
